image_gray_converter: RTL

Downstream stage of `fsm_image_sensor`. Consumes its two-pixel-per-clock RGB stream (VSYNC/HSYNC + DATA_R0..B1) and converts each pixel to 8-bit grayscale with a signed brightness offset and saturation. Tracks column/row position, emits a qualified two-pixel grayscale stream with coordinates, and flags frame completion and framing errors for the image writer that follows.

---
 rtl/image_pkg.sv | 26 ++
 rtl/image_gray_converter_rgb2gray_pipe.sv | 38 +++
 rtl/image_gray_converter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/image_pkg.sv
// Shared constants, FSM state type and saturation helper for the grayscale converter.
package image_pkg;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned COEF_R = 77;
   localparam int unsigned COEF_G = 150;
   localparam int unsigned COEF_B = 29;

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StDone
   } state_e;

   // Clamp a 10-bit signed luma+offset value into the 0..255 pixel range.
   function automatic logic [PIX_W-1:0] sat_pix(input logic signed [9:0] z);
      if (z[9]) begin
         return '0;
      end else if (z[8]) begin
         return '1;
      end else begin
         return z[PIX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/image_gray_converter_rgb2gray_pipe.sv
// Two-stage single-pixel RGB to grayscale conversion with signed brightness offset and clamp.
module rgb2gray_pipe
   import image_pkg::*;
#(
   parameter logic signed [8:0] BRIGHT = 9'sd0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] r,
   input  logic [PIX_W-1:0] g,
   input  logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] gray
);

   logic [15:0]       sum_d;
   logic [15:0]       sum_q;
   logic signed [9:0] z;

   // Max 255*256 = 65280, so the 16-bit sum never overflows.
   always_comb begin
      sum_d = 16'(COEF_R) * {8'd0, r} + 16'(COEF_G) * {8'd0, g} + 16'(COEF_B) * {8'd0, b};
   end

   always_comb begin
      z = $signed(10'(sum_q >> 8)) + $signed({BRIGHT[8], BRIGHT});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         gray  <= '0;
      end else begin
         sum_q <= sum_d;
         gray  <= sat_pix(z);
      end
   end

endmodule

// File: rtl/image_gray_converter.sv
// Two-pixel-per-clock RGB to grayscale stage with frame tracking, coordinate tags and error flag.
module image_gray_converter
   import image_pkg::*;
#(
   parameter int unsigned       WIDTH  = 768,
   parameter int unsigned       HEIGHT = 512,
   parameter logic signed [8:0] BRIGHT = 9'sd0,
   localparam int unsigned      CW     = $clog2(WIDTH),
   localparam int unsigned      RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             VSYNC,
   input  logic             HSYNC,
   input  logic [PIX_W-1:0] DATA_R0,
   input  logic [PIX_W-1:0] DATA_G0,
   input  logic [PIX_W-1:0] DATA_B0,
   input  logic [PIX_W-1:0] DATA_R1,
   input  logic [PIX_W-1:0] DATA_G1,
   input  logic [PIX_W-1:0] DATA_B1,
   output logic [PIX_W-1:0] GRAY0,
   output logic [PIX_W-1:0] GRAY1,
   output logic             out_valid,
   output logic [CW-1:0]    col,
   output logic [RW-1:0]    row,
   output logic             frame_done,
   output logic             err_frame
);

   state_e        state_q, state_d;
   logic [CW-1:0] col_cnt_q, col_cnt_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [CW-1:0] eff_col, tag_col;
   logic [RW-1:0] eff_row, tag_row;
   logic          accept, tag_last, err_d;

   logic          s1_valid, s1_last;
   logic [CW-1:0] s1_col;
   logic [RW-1:0] s1_row;

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      accept    = 1'b0;
      tag_last  = 1'b0;
      err_d     = 1'b0;
      // A VSYNC while active restarts the frame; a same-cycle pair becomes its (0,0).
      eff_col   = VSYNC ? '0 : col_cnt_q;
      eff_row   = VSYNC ? '0 : row_cnt_q;
      tag_col   = eff_col;
      tag_row   = eff_row;
      unique case (state_q)
         StIdle, StDone: begin
            if (VSYNC) begin
               state_d   = StActive;
               col_cnt_d = '0;
               row_cnt_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StActive: begin
            err_d     = VSYNC;
            col_cnt_d = eff_col;
            row_cnt_d = eff_row;
            if (HSYNC) begin
               accept = 1'b1;
               if (eff_col == CW'(WIDTH - 2)) begin
                  col_cnt_d = '0;
                  row_cnt_d = eff_row + RW'(1);
                  if (eff_row == RW'(HEIGHT - 1)) begin
                     tag_last = 1'b1;
                     state_d  = StDone;
                  end
               end else begin
                  col_cnt_d = eff_col + CW'(2);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= StIdle;
         col_cnt_q  <= '0;
         row_cnt_q  <= '0;
         err_frame  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_col     <= '0;
         s1_row     <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         col        <= '0;
         row        <= '0;
      end else begin
         state_q    <= state_d;
         col_cnt_q  <= col_cnt_d;
         row_cnt_q  <= row_cnt_d;
         err_frame  <= err_d;
         s1_valid   <= accept;
         s1_last    <= tag_last;
         s1_col     <= tag_col;
         s1_row     <= tag_row;
         out_valid  <= s1_valid;
         frame_done <= s1_valid & s1_last;
         col        <= s1_col;
         row        <= s1_row;
      end
   end

   rgb2gray_pipe #(
      .BRIGHT (BRIGHT)
   ) u_pix0 (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .r     (DATA_R0),
      .g     (DATA_G0),
      .b     (DATA_B0),
      .gray  (GRAY0)
   );

   rgb2gray_pipe #(
      .BRIGHT (BRIGHT)
   ) u_pix1 (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .r     (DATA_R1),
      .g     (DATA_G1),
      .b     (DATA_B1),
      .gray  (GRAY1)
   );

endmodule
